stbus_rx_deframer: RTL and testbench
====================================

Name: stbus_rx_deframer

Overview:
ST-BUS serial receive deframer on the c4 domain. It locks to the active-low f0 frame pulse and samples the 2.048 Mb/s data_from_dt stream at two c4 cycles per bit, MSB first. It emits one parallel byte per timeslot with the channel number and a valid strobe. It also reports frame-sync health and raises cpu_int once per frame on a selected channel. It sits directly downstream of the DT serial input and feeds channel bytes to the register and CPU side.

Parameters:
CHANNELS, 32, timeslots per frame; frame length FRAME = 16*CHANNELS c4 cycles (512 at default)
SAMPLE_PHASE, 1, c4 cycle within each bit at which data is sampled (0 or 1)
IRQ_CHANNEL, 31, channel whose byte completion sets cpu_int (0..CHANNELS-1)

Ports:
c4  input  1  4.096 MHz bit clock; all logic on the rising edge
reset_in_rg  input  1  asynchronous, active-low reset
f0  input  1  frame pulse, active low, sampled on c4 rising edge
data_in  input  1  serial ST-BUS data (from data_from_dt)
enable  input  1  1 = byte outputs and irq active; 0 = framing continues, outputs suppressed
int_ack  input  1  one-cycle pulse that clears cpu_int
rx_byte  output  8  last received channel byte
rx_chan  output  clog2(CHANNELS)  channel index of rx_byte
rx_valid  output  1  one-cycle strobe: rx_byte/rx_chan updated
frame_start  output  1  one-cycle pulse on each accepted f0
sync_err  output  1  one-cycle pulse on a framing error
sync_lost  output  1  level, 1 while in HUNT
cpu_int  output  1  level interrupt request

Behaviour:
- Reset values: rx_byte=0, rx_chan=0, rx_valid=0, frame_start=0, sync_err=0, sync_lost=1, cpu_int=0, state=HUNT, counter=0, shift register=0.
- Counter: clog2(FRAME) bits. f0==0 at an edge sets counter to 0 on the next cycle. Otherwise counter increments (in SYNC only).
- States:
  - HUNT: no sampling, no rx_valid. f0==0 -> SYNC, counter<=0, frame_start pulse.
  - SYNC, f0==0 at counter==FRAME-1: normal frame boundary; counter<=0, frame_start pulse.
  - SYNC, f0==0 at any other count: resync. The byte in progress and the sample on that edge are discarded. Counter<=0, sync_err and frame_start pulse, stay in SYNC.
  - SYNC, counter==FRAME-1 and f0==1: missed frame. Go to HUNT, sync_err pulse, sync_lost<=1. The channel CHANNELS-1 byte completing on that edge is still emitted.
- Sampling (SYNC only): bit k (0..8*CHANNELS-1) is taken when current counter==2k+SAMPLE_PHASE. It is shifted into the shift register MSB first. This happens regardless of f0 at a normal boundary, so with SAMPLE_PHASE=1 the last bit is sampled on the f0 edge itself.
- Byte completion: when k%8==7, on the same edge:
  - rx_byte<={shift[6:0],data_in}
  - rx_chan<=k/8
  - rx_valid<=enable
  - Outputs are visible the cycle after the last-bit edge.
  - rx_byte/rx_chan are not updated when enable==0.
- rx_valid is high for exactly one cycle. There are CHANNELS strobes per error-free frame, spaced 16 cycles apart.
- sync_lost: clears on the HUNT->SYNC transition; sets on the missed-frame transition.
- cpu_int:
  - Set when a byte for IRQ_CHANNEL completes and enable==1.
  - Cleared by int_ack.
  - Set and int_ack on the same edge -> set wins.
  - Holds through sync loss.
- enable may change at any time and takes effect on the next completing byte.
- Reset mid-frame: all state returns to the reset values immediately, and the block must re-hunt f0.

Test Plan:
- Reset, then f0 low for 1 cycle, then channel 0 bits for 0xA5 at SAMPLE_PHASE=1 -> frame_start 1 cycle after the f0 edge; rx_valid 1 cycle after counter==15 with rx_byte=0xA5, rx_chan=0; sync_lost falls to 0.
- Full frame with channel c = c XOR 0x3C, f0 low at counter 511 -> 32 rx_valid strobes 16 cycles apart with correct bytes; channel 31 emitted on the f0 edge; cpu_int=1 after channel 31; no sync_err.
- cpu_int set, int_ack pulsed on the same edge as the next frame's channel 31 completion -> cpu_int stays 1; int_ack alone later -> cpu_int=0.
- f0 low at counter 200 -> sync_err pulse; partial channel 12 discarded; next rx_valid is channel 0 of the new frame, 16 cycles later.
- f0 held high past counter 511 -> sync_err, sync_lost=1, channel 31 byte still emitted; no rx_valid until the next f0.
- enable=0 for a whole frame -> zero rx_valid, rx_byte unchanged, cpu_int not set, frame_start still pulses; enable=1 mid-frame -> strobes resume at the next completed channel.

Source files
------------

// File: rtl/stbus_rx_deframer_if.sv
// ST-BUS receive deframer bus: serial/control inputs and byte/status outputs.
interface stbus_rx_deframer_if #(
    parameter int unsigned CHANNELS = 32
);
    localparam int unsigned CHW = $clog2(CHANNELS);

    logic           f0;
    logic           data_in;
    logic           enable;
    logic           int_ack;
    logic [7:0]     rx_byte;
    logic [CHW-1:0] rx_chan;
    logic           rx_valid;
    logic           frame_start;
    logic           sync_err;
    logic           sync_lost;
    logic           cpu_int;

    modport master (
        output f0, data_in, enable, int_ack,
        input  rx_byte, rx_chan, rx_valid, frame_start, sync_err, sync_lost, cpu_int
    );

    modport slave (
        input  f0, data_in, enable, int_ack,
        output rx_byte, rx_chan, rx_valid, frame_start, sync_err, sync_lost, cpu_int
    );
endinterface

// File: rtl/stbus_rx_deframer.sv
// ST-BUS serial receive deframer: locks to f0, samples 2 c4 cycles per bit,
// emits one byte per timeslot, reports sync health and a per-frame interrupt.
module stbus_rx_deframer #(
    parameter int unsigned CHANNELS     = 32,
    parameter int unsigned SAMPLE_PHASE = 1,
    parameter int unsigned IRQ_CHANNEL  = 31
) (
    input logic                c4,
    input logic                reset_in_rg,
    stbus_rx_deframer_if.slave bus
);
    localparam int unsigned CHW   = $clog2(CHANNELS);
    localparam int unsigned CW    = CHW + 4;
    localparam int unsigned FRAME = 16 * CHANNELS;
    localparam logic [CW-1:0]  LAST_CNT = CW'(FRAME - 1);
    localparam logic [CHW-1:0] IRQ_CH   = CHW'(IRQ_CHANNEL);
    localparam logic           PHASE    = 1'(SAMPLE_PHASE);

    typedef enum logic {HUNT = 1'b0, SYNC = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     rx_byte_q, rx_byte_d;
    logic [CHW-1:0] rx_chan_q, rx_chan_d;
    logic           rx_valid_q, rx_valid_d;
    logic           frame_start_q, frame_start_d;
    logic           sync_err_q, sync_err_d;
    logic           sync_lost_q, sync_lost_d;
    logic           cpu_int_q, cpu_int_d;
    logic           sample;
    logic           resync;

    // State register
    always_ff @(posedge c4 or negedge reset_in_rg) begin
        if (!reset_in_rg) begin
            state_q       <= HUNT;
            cnt_q         <= '0;
            shift_q       <= '0;
            rx_byte_q     <= '0;
            rx_chan_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
            sync_lost_q   <= 1'b1;
            cpu_int_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            rx_byte_q     <= rx_byte_d;
            rx_chan_q     <= rx_chan_d;
            rx_valid_q    <= rx_valid_d;
            frame_start_q <= frame_start_d;
            sync_err_q    <= sync_err_d;
            sync_lost_q   <= sync_lost_d;
            cpu_int_q     <= cpu_int_d;
        end
    end

    // Framing, sampling and byte assembly
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        rx_byte_d     = rx_byte_q;
        rx_chan_d     = rx_chan_q;
        rx_valid_d    = 1'b0;
        frame_start_d = 1'b0;
        sync_err_d    = 1'b0;
        sync_lost_d   = sync_lost_q;
        cpu_int_d     = cpu_int_q & ~bus.int_ack;
        sample        = 1'b0;
        resync        = 1'b0;

        if (state_q == HUNT) begin
            if (!bus.f0) begin
                state_d       = SYNC;
                cnt_d         = '0;
                frame_start_d = 1'b1;
                sync_lost_d   = 1'b0;
            end
        end else begin
            resync = !bus.f0 && (cnt_q != LAST_CNT);
            sample = (cnt_q[0] == PHASE) && !resync;
            if (resync) begin
                // Early f0: drop the partial byte and restart the frame
                cnt_d         = '0;
                shift_d       = '0;
                sync_err_d    = 1'b1;
                frame_start_d = 1'b1;
            end else if (cnt_q == LAST_CNT) begin
                cnt_d = '0;
                if (bus.f0) begin
                    state_d     = HUNT;
                    sync_err_d  = 1'b1;
                    sync_lost_d = 1'b1;
                end else begin
                    frame_start_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (sample) begin
            shift_d = {shift_q[6:0], bus.data_in};
            // cnt[3:1] is the bit index within the timeslot, cnt[CW-1:4] the channel
            if (cnt_q[3:1] == 3'd7) begin
                rx_valid_d = bus.enable;
                if (bus.enable) begin
                    rx_byte_d = {shift_q[6:0], bus.data_in};
                    rx_chan_d = cnt_q[CW-1:4];
                    if (cnt_q[CW-1:4] == IRQ_CH) begin
                        cpu_int_d = 1'b1;
                    end
                end
            end
        end
    end

    assign bus.rx_byte     = rx_byte_q;
    assign bus.rx_chan     = rx_chan_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.sync_err    = sync_err_q;
    assign bus.sync_lost   = sync_lost_q;
    assign bus.cpu_int     = cpu_int_q;

endmodule

// File: tb/tb_stbus_rx_deframer.sv
// Directed bench for stbus_rx_deframer: frame-level model plus literal pins.
module tb_stbus_rx_deframer;
    localparam int CH    = 32;
    localparam int FRAME = 16 * CH;
    localparam int SP    = 1;
    localparam int IRQ   = 31;

    logic c4;
    logic rst_n;
    stbus_rx_deframer_if #(.CHANNELS(CH)) bus ();

    stbus_rx_deframer #(.CHANNELS(CH), .SAMPLE_PHASE(SP), .IRQ_CHANNEL(IRQ)) dut (
        .c4(c4), .reset_in_rg(rst_n), .bus(bus)
    );

    initial c4 = 1'b0;
    always #5 c4 = ~c4;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Behavioural model: lock flag, position since last accepted f0, received bit array
    bit m_locked;
    int m_pos;
    bit m_bits [8*CH];
    int exp_byte, exp_chan, exp_valid, exp_fs, exp_err, exp_lost, exp_int;

    task automatic model_reset();
        m_locked = 0; m_pos = 0;
        exp_byte = 0; exp_chan = 0; exp_valid = 0; exp_fs = 0; exp_err = 0;
        exp_lost = 1; exp_int = 0;
    endtask

    task automatic model_step(input bit f0v, input bit dv, input bit en, input bit ack);
        int new_int, k, c, b;
        bit early;
        exp_valid = 0; exp_fs = 0; exp_err = 0;
        new_int = (exp_int != 0 && !ack) ? 1 : 0;
        if (!m_locked) begin
            if (!f0v) begin
                m_locked = 1; m_pos = 0; exp_fs = 1; exp_lost = 0;
            end
        end else begin
            early = !f0v && (m_pos != FRAME - 1);
            if (!early && (m_pos % 2 == SP)) begin
                k = m_pos / 2;
                m_bits[k] = dv;
                if (k % 8 == 7) begin
                    c = k / 8;
                    b = 0;
                    for (int i = 0; i < 8; i++) b = b * 2 + int'(m_bits[8*c + i]);
                    exp_valid = en ? 1 : 0;
                    if (en) begin
                        exp_byte = b; exp_chan = c;
                        if (c == IRQ) new_int = 1;
                    end
                end
            end
            if (early) begin
                m_pos = 0; exp_err = 1; exp_fs = 1;
            end else if (m_pos == FRAME - 1) begin
                m_pos = 0;
                if (f0v) begin
                    m_locked = 0; exp_err = 1; exp_lost = 1;
                end else begin
                    exp_fs = 1;
                end
            end else begin
                m_pos++;
            end
        end
        exp_int = new_int;
    endtask

    // Every-cycle comparison against the model
    bit chk_en = 0;
    always @(negedge c4) begin
        if (chk_en) begin
            chk("rx_valid", int'(bus.rx_valid), exp_valid);
            chk("rx_byte", int'(bus.rx_byte), exp_byte);
            chk("rx_chan", int'(bus.rx_chan), exp_chan);
            chk("frame_start", int'(bus.frame_start), exp_fs);
            chk("sync_err", int'(bus.sync_err), exp_err);
            chk("sync_lost", int'(bus.sync_lost), exp_lost);
            chk("cpu_int", int'(bus.cpu_int), exp_int);
        end
    end

    // Stimulus state
    logic [7:0] frame_bytes [CH];
    bit cur_en = 1;
    bit cur_ack = 0;
    int d_pos = 0;
    int s_valid = 0, s_fs = 0, s_err = 0, s_first_chan = -1;

    task automatic tick(input logic f0v, input logic dv);
        bus.f0 = f0v; bus.data_in = dv; bus.enable = cur_en; bus.int_ack = cur_ack;
        @(posedge c4);
        model_step(f0v, dv, cur_en, cur_ack);
        @(negedge c4);
        if (bus.rx_valid) begin
            if (s_valid == 0) s_first_chan = int'(bus.rx_chan);
            s_valid++;
        end
        s_fs += int'(bus.frame_start);
        s_err += int'(bus.sync_err);
    endtask

    task automatic tick_auto(input logic f0v);
        int k;
        logic [7:0] byt;
        k = (d_pos / 2) % (8 * CH);
        byt = frame_bytes[k / 8];
        tick(f0v, byt[7 - (k % 8)]);
        d_pos = f0v ? d_pos + 1 : 0;
    endtask

    task automatic run_to(input int pos);
        while (d_pos < pos) tick_auto(1'b1);
    endtask

    task automatic clear_counts();
        s_valid = 0; s_fs = 0; s_err = 0; s_first_chan = -1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rx_byte"}, int'(bus.rx_byte), 0);
        chk({tag, "_rx_chan"}, int'(bus.rx_chan), 0);
        chk({tag, "_rx_valid"}, int'(bus.rx_valid), 0);
        chk({tag, "_frame_start"}, int'(bus.frame_start), 0);
        chk({tag, "_sync_err"}, int'(bus.sync_err), 0);
        chk({tag, "_sync_lost"}, int'(bus.sync_lost), 1);
        chk({tag, "_cpu_int"}, int'(bus.cpu_int), 0);
    endtask

    initial begin
        for (int c = 0; c < CH; c++) frame_bytes[c] = 8'(c ^ 8'h3C);
        frame_bytes[0] = 8'hA5;
        bus.f0 = 1'b1; bus.data_in = 1'b0; bus.enable = 1'b1; bus.int_ack = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge c4);
        chk_reset_vals("reset");
        chk_en = 1;
        rst_n = 1'b1;
        repeat (4) tick(1'b1, 1'b1);
        chk("hunt_sync_lost", int'(bus.sync_lost), 1);

        // First lock and channel 0 = 0xA5
        tick_auto(1'b0);
        chk("lock_frame_start", int'(bus.frame_start), 1);
        chk("lock_sync_lost", int'(bus.sync_lost), 0);
        clear_counts();
        repeat (16) tick_auto(1'b1);
        chk("ch0_valid", int'(bus.rx_valid), 1);
        chk("ch0_byte", int'(bus.rx_byte), 8'hA5);
        chk("ch0_chan", int'(bus.rx_chan), 0);

        // Rest of frame; channel 31 completes on the f0 edge
        run_to(FRAME - 1);
        tick_auto(1'b0);
        chk("f1_strobes", s_valid, 32);
        chk("f1_sync_err", s_err, 0);
        chk("ch31_valid", int'(bus.rx_valid), 1);
        chk("ch31_chan", int'(bus.rx_chan), 31);
        chk("ch31_byte", int'(bus.rx_byte), 8'h23);
        chk("ch31_cpu_int", int'(bus.cpu_int), 1);
        chk("f2_frame_start", int'(bus.frame_start), 1);
        frame_bytes[0] = 8'h3C;

        // int_ack coinciding with the irq channel completion: set wins
        run_to(FRAME - 1);
        cur_ack = 1;
        tick_auto(1'b0);
        cur_ack = 0;
        chk("ack_collide_cpu_int", int'(bus.cpu_int), 1);
        repeat (5) tick_auto(1'b1);
        cur_ack = 1;
        tick_auto(1'b1);
        cur_ack = 0;
        chk("ack_clears_cpu_int", int'(bus.cpu_int), 0);

        // Early f0 at counter 200 discards partial channel 12
        run_to(200);
        clear_counts();
        tick_auto(1'b0);
        chk("resync_err", int'(bus.sync_err), 1);
        chk("resync_fs", int'(bus.frame_start), 1);
        chk("resync_no_valid", int'(bus.rx_valid), 0);
        repeat (15) tick_auto(1'b1);
        chk("resync_quiet", s_valid, 0);
        tick_auto(1'b1);
        chk("resync_ch0_valid", int'(bus.rx_valid), 1);
        chk("resync_ch0_chan", int'(bus.rx_chan), 0);
        chk("resync_ch0_byte", int'(bus.rx_byte), 8'h3C);

        // Missed f0: channel 31 still emitted, then hunt
        run_to(FRAME - 1);
        tick_auto(1'b1);
        chk("miss_err", int'(bus.sync_err), 1);
        chk("miss_lost", int'(bus.sync_lost), 1);
        chk("miss_ch31_valid", int'(bus.rx_valid), 1);
        chk("miss_ch31_chan", int'(bus.rx_chan), 31);
        clear_counts();
        repeat (40) tick_auto(1'b1);
        chk("hunt_no_valid", s_valid, 0);
        chk("hunt_lost_held", int'(bus.sync_lost), 1);
        chk("hunt_cpu_int_held", int'(bus.cpu_int), 1);
        cur_ack = 1;
        tick_auto(1'b1);
        cur_ack = 0;

        // Whole frame with enable low, then re-enable mid-frame
        cur_en = 0;
        tick_auto(1'b0);
        clear_counts();
        run_to(FRAME - 1);
        tick_auto(1'b0);
        chk("dis_strobes", s_valid, 0);
        chk("dis_byte_held", int'(bus.rx_byte), 8'h23);
        chk("dis_cpu_int", int'(bus.cpu_int), 0);
        chk("dis_frame_start", s_fs, 1);
        run_to(100);
        cur_en = 1;
        clear_counts();
        run_to(112);
        chk("reen_strobes", s_valid, 1);
        chk("reen_first_chan", s_first_chan, 6);

        // Reset mid-frame, then re-hunt
        run_to(300);
        @(posedge c4);
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge c4);
        chk_reset_vals("midreset");
        repeat (2) @(negedge c4);
        rst_n = 1'b1;
        clear_counts();
        repeat (5) tick_auto(1'b1);
        chk("rehunt_lost", int'(bus.sync_lost), 1);
        chk("rehunt_no_valid", s_valid, 0);
        tick_auto(1'b0);
        repeat (16) tick_auto(1'b1);
        chk("relock_ch0_valid", int'(bus.rx_valid), 1);
        chk("relock_ch0_byte", int'(bus.rx_byte), 8'h3C);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
